// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared pipeline widths, aluOp encodings and ID/EX register layout.
package id_ex_stage_pkg;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_NOR = 3'd5,
        ALU_XOR = 3'd6,
        ALU_LUI = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic       regDst;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       aluSrc;
        logic [2:0] aluOp;
    } ctrl_t;

    // A bubble must never write state; the remaining fields are zeroed as well.
    localparam ctrl_t BUBBLE_CTRL = '0;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        ctrl_t             ctrl;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
    } ex_state_t;
endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: load-use hazard between a load in EX and the instruction in ID.
module hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             hz
);
    assign hz = ex_valid & ex_mem_read & (ex_dest != '0) & id_valid &
                ((ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt)));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, bubble insertion,
// WB write bypass into captured operands and a saturating stall counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_uses_rt,
    input  logic              id_regDst,
    input  logic              id_regWrite,
    input  logic              id_memRead,
    input  logic              id_memWrite,
    input  logic              id_memToReg,
    input  logic              id_aluSrc,
    input  logic [2:0]        id_aluOp,
    input  logic [DATA_W-1:0] id_readData1,
    input  logic [DATA_W-1:0] id_readData2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              wb_regWrite,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [REG_W-1:0]  ex_dest,
    output logic              ex_regDst,
    output logic              ex_regWrite,
    output logic              ex_memRead,
    output logic              ex_memWrite,
    output logic              ex_memToReg,
    output logic              ex_aluSrc,
    output logic [2:0]        ex_aluOp,
    output logic [DATA_W-1:0] ex_readData1,
    output logic [DATA_W-1:0] ex_readData2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CNT_W-1:0]  stall_count
);
    ex_state_t d, q;
    logic      hz;

    hazard_detect u_hazard_detect (
        .ex_valid    (q.valid),
        .ex_mem_read (q.ctrl.memRead),
        .ex_dest     (ex_dest),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .hz          (hz)
    );

    assign stall = hz & ~flush;

    always_comb begin
        d = '0;
        d.ctrl = BUBBLE_CTRL;
        if (!(flush || hz)) begin
            d.valid = id_valid;
            d.rs    = id_rs;
            d.rt    = id_rt;
            d.rd    = id_rd;
            d.ctrl  = '{regDst: id_regDst, regWrite: id_regWrite, memRead: id_memRead,
                        memWrite: id_memWrite, memToReg: id_memToReg, aluSrc: id_aluSrc,
                        aluOp: id_aluOp};
            // Register 0 is hardwired, so a WB write to it is never forwarded.
            d.rd1   = (wb_regWrite && wb_rd != '0 && wb_rd == id_rs) ? wb_data : id_readData1;
            d.rd2   = (wb_regWrite && wb_rd != '0 && wb_rd == id_rt) ? wb_data : id_readData2;
            d.imm   = id_imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_count <= '0;
        else if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
    end

    assign ex_valid     = q.valid;
    assign ex_rs        = q.rs;
    assign ex_rt        = q.rt;
    assign ex_rd        = q.rd;
    assign ex_dest      = q.ctrl.regDst ? q.rd : q.rt;
    assign ex_regDst    = q.ctrl.regDst;
    assign ex_regWrite  = q.ctrl.regWrite;
    assign ex_memRead   = q.ctrl.memRead;
    assign ex_memWrite  = q.ctrl.memWrite;
    assign ex_memToReg  = q.ctrl.memToReg;
    assign ex_aluSrc    = q.ctrl.aluSrc;
    assign ex_aluOp     = q.ctrl.aluOp;
    assign ex_readData1 = q.rd1;
    assign ex_readData2 = q.rd2;
    assign ex_imm       = q.imm;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of hazard stall, bubbles, WB bypass, counter saturation and async reset.
module tb_id_ex_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        id_valid = 0, id_uses_rt = 0;
    logic [4:0]  id_rs = 0, id_rt = 0, id_rd = 0;
    logic        id_regDst = 0, id_regWrite = 0, id_memRead = 0, id_memWrite = 0;
    logic        id_memToReg = 0, id_aluSrc = 0;
    logic [2:0]  id_aluOp = 0;
    logic [31:0] id_readData1 = 0, id_readData2 = 0, id_imm = 0;
    logic        wb_regWrite = 0;
    logic [4:0]  wb_rd = 0;
    logic [31:0] wb_data = 0;
    logic        flush = 0;
    logic        stall, ex_valid, ex_regDst, ex_regWrite, ex_memRead, ex_memWrite;
    logic        ex_memToReg, ex_aluSrc;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_dest;
    logic [2:0]  ex_aluOp;
    logic [31:0] ex_readData1, ex_readData2, ex_imm;
    logic [3:0]  stall_count;
    int          vectors = 0, errs = 0;
    int          exp_cnt;

    id_ex_stage #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rt(id_uses_rt), .id_regDst(id_regDst), .id_regWrite(id_regWrite),
        .id_memRead(id_memRead), .id_memWrite(id_memWrite), .id_memToReg(id_memToReg),
        .id_aluSrc(id_aluSrc), .id_aluOp(id_aluOp), .id_readData1(id_readData1),
        .id_readData2(id_readData2), .id_imm(id_imm), .wb_regWrite(wb_regWrite), .wb_rd(wb_rd),
        .wb_data(wb_data), .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_dest(ex_dest), .ex_regDst(ex_regDst),
        .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
        .ex_memToReg(ex_memToReg), .ex_aluSrc(ex_aluSrc), .ex_aluOp(ex_aluOp),
        .ex_readData1(ex_readData1), .ex_readData2(ex_readData2), .ex_imm(ex_imm),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic urt, input logic rdst,
                          input logic rw, input logic mr, input logic [31:0] d1,
                          input logic [31:0] d2);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = urt;
        id_regDst = rdst; id_regWrite = rw; id_memRead = mr; id_memToReg = mr; id_aluSrc = mr;
        id_readData1 = d1; id_readData2 = d2;
    endtask

    initial begin
        #2;
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_cnt", 32'(stall_count), 0);
        chk("rst_rd1", ex_readData1, 0);
        chk("rst_stall", 32'(stall), 0);
        #10 rst = 0;
        tick();
        // 1: lw $8 then dependent add
        set_id(1, 5'd1, 5'd8, 5'd0, 0, 0, 1, 1, 32'd100, 32'd0);
        id_imm = 32'd4; id_aluOp = 3'd2;
        tick();
        chk("lw_memread", 32'(ex_memRead), 1);
        chk("lw_dest", 32'(ex_dest), 8);
        chk("lw_imm", ex_imm, 4);
        chk("lw_aluop", 32'(ex_aluOp), 2);
        set_id(1, 5'd8, 5'd2, 5'd3, 1, 1, 1, 0, 32'd11, 32'd22);
        id_imm = 0; id_aluOp = 0;
        #1 chk("lu_stall", 32'(stall), 1);
        tick();
        chk("lu_bub_valid", 32'(ex_valid), 0);
        chk("lu_bub_rw", 32'(ex_regWrite), 0);
        chk("lu_bub_mr", 32'(ex_memRead), 0);
        chk("lu_cnt", 32'(stall_count), 1);
        chk("lu_stall_drop", 32'(stall), 0);
        tick();
        chk("add_valid", 32'(ex_valid), 1);
        chk("add_dest", 32'(ex_dest), 3);
        chk("add_rs", 32'(ex_rs), 8);
        chk("add_rd1", ex_readData1, 11);
        chk("add_rd2", ex_readData2, 22);
        chk("add_cnt", 32'(stall_count), 1);
        // 2a: load to $0 never stalls
        set_id(1, 5'd1, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0);
        tick();
        set_id(1, 5'd0, 5'd0, 5'd4, 1, 1, 1, 0, 0, 0);
        #1 chk("r0_nostall", 32'(stall), 0);
        // 2b: rt match without rt use
        set_id(1, 5'd1, 5'd9, 5'd0, 0, 0, 1, 1, 0, 0);
        tick();
        chk("lw9_dest", 32'(ex_dest), 9);
        set_id(1, 5'd1, 5'd9, 5'd4, 0, 1, 1, 0, 0, 0);
        #1 chk("rt_unused_nostall", 32'(stall), 0);
        id_uses_rt = 1;
        #1 chk("rt_used_stall", 32'(stall), 1);
        // 3: flush beats hazard
        flush = 1;
        #1 chk("flush_stall", 32'(stall), 0);
        tick();
        flush = 0;
        chk("flush_valid", 32'(ex_valid), 0);
        chk("flush_rw", 32'(ex_regWrite), 0);
        chk("flush_cnt", 32'(stall_count), 1);
        // 4: WB bypass
        set_id(1, 5'd5, 5'd5, 5'd6, 1, 1, 1, 0, 0, 0);
        wb_regWrite = 1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        tick();
        chk("byp_rd1", ex_readData1, 32'hDEADBEEF);
        chk("byp_rd2", ex_readData2, 32'hDEADBEEF);
        set_id(1, 5'd0, 5'd0, 5'd6, 1, 1, 1, 0, 32'h1234, 32'h5678);
        wb_rd = 5'd0;
        tick();
        chk("byp_r0_rd1", ex_readData1, 32'h1234);
        chk("byp_r0_rd2", ex_readData2, 32'h5678);
        wb_regWrite = 0; wb_rd = 5'd5;
        set_id(0, 5'd5, 5'd2, 5'd6, 1, 1, 1, 0, 32'hAAAA, 32'hBBBB);
        tick();
        chk("inv_valid", 32'(ex_valid), 0);
        chk("inv_rd1", ex_readData1, 32'hAAAA);
        chk("inv_rw", 32'(ex_regWrite), 1);
        // 5: saturation with 20 stalls
        exp_cnt = 1;
        for (int i = 0; i < 20; i++) begin
            set_id(1, 5'd1, 5'd7, 5'd0, 0, 0, 1, 1, 0, 0);
            tick();
            set_id(1, 5'd7, 5'd2, 5'd3, 1, 1, 1, 0, 0, 0);
            tick();
            exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
            chk("sat_cnt", 32'(stall_count), 32'(exp_cnt));
        end
        chk("sat_final", 32'(stall_count), 15);
        // 6: async reset during a stall
        set_id(1, 5'd1, 5'd7, 5'd0, 0, 0, 1, 1, 0, 0);
        tick();
        set_id(1, 5'd7, 5'd2, 5'd3, 1, 1, 1, 0, 32'd77, 0);
        #1 chk("pre_rst_stall", 32'(stall), 1);
        #2 rst = 1;
        #1;
        chk("arst_valid", 32'(ex_valid), 0);
        chk("arst_mr", 32'(ex_memRead), 0);
        chk("arst_dest", 32'(ex_dest), 0);
        chk("arst_cnt", 32'(stall_count), 0);
        chk("arst_stall", 32'(stall), 0);
        #1 rst = 0;
        #1 chk("post_rst_stall", 32'(stall), 0);
        tick();
        chk("post_rst_valid", 32'(ex_valid), 1);
        chk("post_rst_rs", 32'(ex_rs), 7);
        chk("post_rst_rd1", ex_readData1, 77);
        chk("post_rst_cnt", 32'(stall_count), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
